// File: rtl/csr_access_ctrl_pkg.sv
// csr_access_ctrl_pkg
// Shared constants for the CSR access controller: operation encodings,
// controller states, exception codes and architectural CSR numbers.
// No ports; imported by csr_access_ctrl.
package csr_access_ctrl_pkg;

  // CSR number width; must match the CSR register file.
  localparam int CSR_NUM_WIDTH = 14;

  // Operations issued by the execute stage; 7 is reserved and behaves as NOP.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_SYSCALL = 3'd5,
    OP_BREAK   = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CMT  = 2'd2
  } state_e;

  // Exception codes
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;

  // CSR numbers
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_CRMD   = 14'h0000;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_PRMD   = 14'h0001;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_ESTAT  = 14'h0005;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_ERA    = 14'h0006;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_EENTRY = 14'h000C;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE0  = 14'h0030;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE1  = 14'h0031;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE2  = 14'h0032;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE3  = 14'h0033;

  // Ops that read a CSR in the RD state (ERTN reads ERA).
  function automatic logic op_reads_csr(input op_e op);
    logic r;
    case (op)
      OP_CSRRD, OP_CSRWR, OP_CSRXCHG, OP_ERTN: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that go through RD/CMT; NOP and the reserved code do nothing.
  function automatic logic op_is_active(input op_e op);
    logic r;
    case (op)
      OP_NOP, OP_RSVD: r = 1'b0;
      default:         r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
// Sequences one CSR-class instruction at a time through IDLE -> RD -> CMT.
// RD reads the target CSR (or ERA for ERTN); CMT issues the CSR write,
// GPR writeback, exception/return commit and front-end redirect as
// single-cycle pulses. Throughput is one instruction per three cycles.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               handshake from execute stage
//   in_op, in_csr_num, in_rd_val,
//   in_rj_val, in_pc, in_dest       instruction fields
//   in_cancel                       kill of the held instruction (RD only)
//   csr_re/num/we/wmask/wvalue      CSR file access port
//   csr_rvalue, ex_entry            CSR read data, exception entry address
//   wb_ex/pc/ecode/esubcode,
//   ertn_flush                      exception/return commit
//   rf_we/waddr/wdata               GPR writeback
//   flush_valid/flush_target        front-end redirect
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [CSR_NUM_WIDTH-1:0] in_csr_num,
  input  logic [31:0]              in_rd_val,
  input  logic [31:0]              in_rj_val,
  input  logic [31:0]              in_pc,
  input  logic [4:0]               in_dest,
  input  logic                     in_cancel,
  output logic                     csr_re,
  output logic [CSR_NUM_WIDTH-1:0] csr_num,
  output logic                     csr_we,
  output logic [31:0]              csr_wmask,
  output logic [31:0]              csr_wvalue,
  input  logic [31:0]              csr_rvalue,
  input  logic [31:0]              ex_entry,
  output logic                     wb_ex,
  output logic [31:0]              wb_pc,
  output logic [5:0]               wb_ecode,
  output logic [8:0]               wb_esubcode,
  output logic                     ertn_flush,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     flush_valid,
  output logic [31:0]              flush_target
);

  state_e                     state_q,   state_d;
  op_e                        op_q,      op_d;
  logic [CSR_NUM_WIDTH-1:0]   num_q,     num_d;
  logic [31:0]                rd_val_q,  rd_val_d;
  logic [31:0]                rj_val_q,  rj_val_d;
  logic [31:0]                pc_q,      pc_d;
  logic [4:0]                 dest_q,    dest_d;
  logic [31:0]                old_val_q, old_val_d;

  logic                       rf_wr_s;
  logic [CSR_NUM_WIDTH-1:0]   sel_num_s;

  // Next-state and field-latch logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    num_d     = num_q;
    rd_val_d  = rd_val_q;
    rj_val_d  = rj_val_q;
    pc_d      = pc_q;
    dest_d    = dest_q;
    old_val_d = old_val_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = op_e'(in_op);
          num_d    = in_csr_num;
          rd_val_d = in_rd_val;
          rj_val_d = in_rj_val;
          pc_d     = in_pc;
          dest_d   = in_dest;
          if (op_is_active(op_e'(in_op))) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        // SYSCALL/BREAK do not read; keep old_val clean for them.
        if (op_reads_csr(op_q)) begin
          old_val_d = csr_rvalue;
        end else begin
          old_val_d = 32'h0000_0000;
        end
        if (in_cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CMT;
        end
      end
      ST_CMT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      num_q     <= '0;
      rd_val_q  <= 32'h0000_0000;
      rj_val_q  <= 32'h0000_0000;
      pc_q      <= 32'h0000_0000;
      dest_q    <= 5'd0;
      old_val_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      num_q     <= num_d;
      rd_val_q  <= rd_val_d;
      rj_val_q  <= rj_val_d;
      pc_q      <= pc_d;
      dest_q    <= dest_d;
      old_val_q <= old_val_d;
    end
  end

  // CSR number presented in RD and held unchanged through CMT.
  always_comb begin
    sel_num_s = '0;
    case (op_q)
      OP_CSRRD, OP_CSRWR, OP_CSRXCHG: sel_num_s = num_q;
      OP_ERTN:                        sel_num_s = CSR_ERA;
      default:                        sel_num_s = '0;
    endcase
  end

  assign rf_wr_s = (dest_q != 5'd0);

  // Output decode; everything is forced low during a reset cycle so an
  // aborted instruction cannot leak a write or flush pulse.
  always_comb begin
    in_ready     = 1'b0;
    csr_re       = 1'b0;
    csr_num      = '0;
    csr_we       = 1'b0;
    csr_wmask    = 32'h0000_0000;
    csr_wvalue   = 32'h0000_0000;
    wb_ex        = 1'b0;
    wb_pc        = 32'h0000_0000;
    wb_ecode     = 6'h00;
    wb_esubcode  = 9'h000;
    ertn_flush   = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = 32'h0000_0000;
    flush_valid  = 1'b0;
    flush_target = 32'h0000_0000;
    if (reset) begin
      in_ready = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
        end
        ST_RD: begin
          csr_re  = op_reads_csr(op_q);
          csr_num = sel_num_s;
        end
        ST_CMT: begin
          csr_num = sel_num_s;
          case (op_q)
            OP_CSRRD: begin
              rf_we    = rf_wr_s;
              rf_waddr = rf_wr_s ? dest_q : 5'd0;
              rf_wdata = rf_wr_s ? old_val_q : 32'h0000_0000;
            end
            OP_CSRWR: begin
              csr_we     = 1'b1;
              csr_wmask  = 32'hFFFF_FFFF;
              csr_wvalue = rd_val_q;
              rf_we      = rf_wr_s;
              rf_waddr   = rf_wr_s ? dest_q : 5'd0;
              rf_wdata   = rf_wr_s ? old_val_q : 32'h0000_0000;
            end
            OP_CSRXCHG: begin
              csr_we     = 1'b1;
              csr_wmask  = rj_val_q;
              csr_wvalue = rd_val_q;
              rf_we      = rf_wr_s;
              rf_waddr   = rf_wr_s ? dest_q : 5'd0;
              rf_wdata   = rf_wr_s ? old_val_q : 32'h0000_0000;
            end
            OP_ERTN: begin
              ertn_flush   = 1'b1;
              flush_valid  = 1'b1;
              flush_target = old_val_q;
            end
            OP_SYSCALL, OP_BREAK: begin
              wb_ex        = 1'b1;
              wb_pc        = pc_q;
              wb_ecode     = (op_q == OP_SYSCALL) ? ECODE_SYS : ECODE_BRK;
              wb_esubcode  = 9'h000;
              flush_valid  = 1'b1;
              flush_target = ex_entry;
            end
            default: begin
              csr_we = 1'b0;
            end
          endcase
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: table of instruction vectors
// with expected RD/CMT outputs queued as a scoreboard, plus directed
// sequences for NOP, cancel, back-to-back throughput and reset aborts.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_val;
  logic [31:0] in_pc;
  logic [4:0]  in_dest;
  logic        in_cancel;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic [31:0] ex_entry;
  logic        wb_ex;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush_valid;
  logic [31:0] flush_target;

  csr_access_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_csr_num(in_csr_num),
    .in_rd_val(in_rd_val), .in_rj_val(in_rj_val),
    .in_pc(in_pc), .in_dest(in_dest), .in_cancel(in_cancel),
    .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue), .ex_entry(ex_entry),
    .wb_ex(wb_ex), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .ertn_flush(ertn_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush_valid(flush_valid), .flush_target(flush_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] rd;
    logic [31:0] rj;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] rvalue;
    logic [31:0] entry;
    logic        x_re;
    logic [13:0] x_num;
    logic        x_we;
    logic [31:0] x_wmask;
    logic [31:0] x_wvalue;
    logic        x_rfwe;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_wbex;
    logic [31:0] x_wbpc;
    logic [5:0]  x_ecode;
    logic        x_ertn;
    logic        x_flush;
    logic [31:0] x_target;
  } vec_t;

  vec_t vecs [7];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic handshake(input logic [2:0] op, input logic [13:0] num, input logic [31:0] rd,
                           input logic [31:0] rj, input logic [31:0] pc, input logic [4:0] dest);
    wait_ready();
    in_valid = 1'b1; in_op = op; in_csr_num = num;
    in_rd_val = rd; in_rj_val = rj; in_pc = pc; in_dest = dest;
    @(posedge clk); #1;
    // scramble inputs so the DUT must rely on its latched copy
    in_valid = 1'b0; in_op = 3'd0; in_csr_num = ~num;
    in_rd_val = ~rd; in_rj_val = ~rj; in_pc = ~pc; in_dest = ~dest;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    csr_rvalue = 32'hDEAD_BEEF;
    ex_entry   = 32'hBAD0_BAD0;
    sb.push_back(v);
    handshake(v.op, v.num, v.rd, v.rj, v.pc, v.dest);
    csr_rvalue = v.rvalue;
    @(negedge clk);
    chk("rd_csr_re",   32'(csr_re),   32'(v.x_re));
    chk("rd_csr_num",  32'(csr_num),  32'(v.x_num));
    chk("rd_in_ready", 32'(in_ready), 32'd0);
    chk("rd_csr_we",   32'(csr_we),   32'd0);
    chk("rd_flush",    32'(flush_valid), 32'd0);
    @(posedge clk); #1;
    csr_rvalue = 32'hDEAD_BEEF;
    ex_entry   = v.entry;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("cmt_csr_re",     32'(csr_re),      32'd0);
      chk("cmt_csr_num",    32'(csr_num),     32'(e.x_num));
      chk("cmt_csr_we",     32'(csr_we),      32'(e.x_we));
      chk("cmt_csr_wmask",  csr_wmask,        e.x_wmask);
      chk("cmt_csr_wvalue", csr_wvalue,       e.x_wvalue);
      chk("cmt_rf_we",      32'(rf_we),       32'(e.x_rfwe));
      chk("cmt_rf_waddr",   32'(rf_waddr),    32'(e.x_waddr));
      chk("cmt_rf_wdata",   rf_wdata,         e.x_wdata);
      chk("cmt_wb_ex",      32'(wb_ex),       32'(e.x_wbex));
      chk("cmt_wb_pc",      wb_pc,            e.x_wbpc);
      chk("cmt_wb_ecode",   32'(wb_ecode),    32'(e.x_ecode));
      chk("cmt_wb_esub",    32'(wb_esubcode), 32'd0);
      chk("cmt_ertn",       32'(ertn_flush),  32'(e.x_ertn));
      chk("cmt_flush",      32'(flush_valid), 32'(e.x_flush));
      chk("cmt_target",     flush_target,     e.x_target);
      chk("cmt_in_ready",   32'(in_ready),    32'd0);
    end
    @(posedge clk); #1;
    ex_entry = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready),    32'd1);
    chk("post_csr_we",   32'(csr_we),      32'd0);
    chk("post_flush",    32'(flush_valid), 32'd0);
  endtask

  initial begin
    int acc [$];
    // op num rd rj pc dest rvalue entry | re num we wmask wvalue rfwe waddr wdata wbex wbpc ecode ertn flush target
    vecs[0] = '{3'd2, 14'h0030, 32'h12345678, 32'h00000000, 32'h1C000000, 5'd4, 32'hAAAA0000, 32'h00000000,
                1'b1, 14'h0030, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 5'd4, 32'hAAAA0000,
                1'b0, 32'h00000000, 6'h00, 1'b0, 1'b0, 32'h00000000};
    vecs[1] = '{3'd3, 14'h0001, 32'h00000007, 32'h00000004, 32'h1C000010, 5'd0, 32'h00000055, 32'h00000000,
                1'b1, 14'h0001, 1'b1, 32'h00000004, 32'h00000007, 1'b0, 5'd0, 32'h00000000,
                1'b0, 32'h00000000, 6'h00, 1'b0, 1'b0, 32'h00000000};
    vecs[2] = '{3'd5, 14'h0030, 32'h00000011, 32'h00000022, 32'h1C000100, 5'd3, 32'h00000099, 32'h1C008000,
                1'b0, 14'h0000, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 5'd0, 32'h00000000,
                1'b1, 32'h1C000100, 6'h0B, 1'b0, 1'b1, 32'h1C008000};
    vecs[3] = '{3'd4, 14'h0005, 32'h00000001, 32'h00000002, 32'h1C000300, 5'd7, 32'h1C000104, 32'h1C008000,
                1'b1, 14'h0006, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 5'd0, 32'h00000000,
                1'b0, 32'h00000000, 6'h00, 1'b1, 1'b1, 32'h1C000104};
    vecs[4] = '{3'd1, 14'h0005, 32'h00000003, 32'h00000003, 32'h1C000400, 5'd31, 32'hCAFEF00D, 32'h00000000,
                1'b1, 14'h0005, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 5'd31, 32'hCAFEF00D,
                1'b0, 32'h00000000, 6'h00, 1'b0, 1'b0, 32'h00000000};
    vecs[5] = '{3'd6, 14'h0000, 32'h00000000, 32'h00000000, 32'h1C000200, 5'd1, 32'h00000000, 32'h1C00C000,
                1'b0, 14'h0000, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 5'd0, 32'h00000000,
                1'b1, 32'h1C000200, 6'h0C, 1'b0, 1'b1, 32'h1C00C000};
    vecs[6] = '{3'd1, 14'h3FFF, 32'h00000000, 32'h00000000, 32'h1C000500, 5'd0, 32'h87654321, 32'h00000000,
                1'b1, 14'h3FFF, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 5'd0, 32'h00000000,
                1'b0, 32'h00000000, 6'h00, 1'b0, 1'b0, 32'h00000000};

    reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_csr_num = 14'h0;
    in_rd_val = 32'h0; in_rj_val = 32'h0; in_pc = 32'h0; in_dest = 5'd0;
    in_cancel = 1'b0; csr_rvalue = 32'h0; ex_entry = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    chk("rst_csr_re",   32'(csr_re),      32'd0);
    chk("rst_csr_num",  32'(csr_num),     32'd0);
    chk("rst_rf_we",    32'(rf_we),       32'd0);
    chk("rst_flush",    32'(flush_valid), 32'd0);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // NOP and reserved op: stay in IDLE, no effects
    for (int k = 0; k < 2; k++) begin
      logic [2:0] nop_op;
      nop_op = (k == 0) ? 3'd0 : 3'd7;
      handshake(nop_op, 14'h0030, 32'h1, 32'h1, 32'h1C000600, 5'd2);
      @(negedge clk);
      chk("nop_in_ready", 32'(in_ready), 32'd1);
      chk("nop_csr_re",   32'(csr_re),   32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("nop_csr_we",   32'(csr_we),   32'd0);
      chk("nop_rf_we",    32'(rf_we),    32'd0);
      @(posedge clk); #1;
    end

    // Cancel in RD: nothing committed, ready one cycle later
    csr_rvalue = 32'h0BAD_0000;
    handshake(3'd2, 14'h0031, 32'h55AA55AA, 32'h0, 32'h1C000700, 5'd9);
    in_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_rd_re", 32'(csr_re), 32'd1);
    @(posedge clk); #1;
    in_cancel = 1'b0;
    @(negedge clk);
    chk("cancel_in_ready", 32'(in_ready), 32'd1);
    chk("cancel_csr_we",   32'(csr_we),   32'd0);
    chk("cancel_rf_we",    32'(rf_we),    32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cancel_csr_we2",  32'(csr_we),   32'd0);
    chk("cancel_rf_we2",   32'(rf_we),    32'd0);

    // Cancel in CMT is ignored
    handshake(3'd2, 14'h0032, 32'h01020304, 32'h0, 32'h1C000800, 5'd9);
    @(posedge clk); #1;
    in_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_cmt_we",    32'(csr_we),   32'd1);
    chk("cancel_cmt_wdata", rf_wdata,      32'h0BAD_0000);
    @(posedge clk); #1;
    in_cancel = 1'b0;

    // Back-to-back CSRRD stream: accepted every third cycle
    in_valid = 1'b1; in_op = 3'd1; in_csr_num = 14'h0033; in_dest = 5'd1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_op = 3'd0;
    chk("b2b_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("b2b_first", 32'(acc[0]), 32'd0);
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    end
    wait_ready();

    // Reset asserted in CMT: no pulses, IDLE next cycle
    csr_rvalue = 32'h1234_0000;
    handshake(3'd2, 14'h0030, 32'hFEEDFACE, 32'h0, 32'h1C000900, 5'd4);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstcmt_csr_we", 32'(csr_we),      32'd0);
    chk("rstcmt_rf_we",  32'(rf_we),       32'd0);
    chk("rstcmt_flush",  32'(flush_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstcmt_ready",  32'(in_ready),    32'd1);
    chk("rstcmt_we2",    32'(csr_we),      32'd0);

    // Reset asserted in RD of a SYSCALL: no exception afterwards
    @(posedge clk); #1;
    handshake(3'd5, 14'h0000, 32'h0, 32'h0, 32'h1C000A00, 5'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd_wb_ex", 32'(wb_ex),    32'd0);
    chk("rstrd_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
